etapa_if: RTL and testbench
===========================

ETAPA_IF -- requirements
Module: etapa_if

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, SHALL be the instruction value driven on instr_out while no valid instruction is held.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 stall  input  1  SHALL be the hazard hold from downstream; 1 = outputs must not change.
REQ-006 branch_taken  input  1  SHALL be the redirect request from the execute stage.
REQ-007 branch_target  input  64  SHALL be the redirect address.
REQ-008 imem_req  output  1  SHALL be the registered instruction-memory request.
REQ-009 imem_addr  output  64  SHALL be the fetch address, stable while imem_req=1 and no ack.
REQ-010 imem_ack  input  1  SHALL be a one-cycle pulse per accepted request, with imem_rdata valid that cycle.
REQ-011 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-012 instr_out  output  32  SHALL be the instruction presented to the IF/ID buffer.
REQ-013 pc_out  output  64  SHALL be the address of instr_out.
REQ-014 valid_out  output  1  SHALL mark instr_out/pc_out as a real instruction (0 = bubble).

Function
REQ-015 The FSM SHALL have the states IDLE, REQ, DISCARD and HOLD; imem_req=1 only in REQ and DISCARD.
REQ-016 IDLE SHALL go to REQ unconditionally on the first clock after reset release.
REQ-017 REQ with ack, no redirect, no stall: instr_out<=imem_rdata, pc_out<=pc, valid_out<=1, pc<=pc+4; state stays REQ with imem_addr=pc+4 the next cycle.
REQ-018 REQ with ack and stall: imem_rdata and pc SHALL be captured in an internal hold register, outputs unchanged, next state HOLD.
REQ-019 REQ without ack: outputs hold when stall=1; otherwise valid_out<=0 (bubble), with instr_out/pc_out unchanged.
REQ-020 HOLD with stall=1: no change; with stall=0: outputs<=hold register, valid_out<=1, pc<=pc+4, next state REQ.
REQ-021 Redirect (branch_taken=1) SHALL have top priority over stall in every state except IDLE: pc<=branch_target with bits [1:0] forced to 0, valid_out<=0, hold register discarded.
REQ-022 Redirect in REQ without ack, or in DISCARD without ack, SHALL go to (or stay in) DISCARD; imem_addr stays at the outstanding address until its ack.
REQ-023 Redirect in REQ with ack SHALL drop imem_rdata and go to REQ with imem_addr=new pc on the next cycle.
REQ-024 DISCARD with ack and no new redirect: imem_rdata dropped, next state REQ at the current pc; DISCARD never updates instr_out/pc_out.
REQ-025 Redirect in HOLD SHALL go to REQ at the new pc.
REQ-026 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 0).
REQ-027 Only one request SHALL ever be outstanding; ack outside REQ/DISCARD SHALL be ignored.

Reset
REQ-028 While rst_n=0, regardless of clk: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_out=NOP_INSTR, pc_out=0, valid_out=0, hold register cleared.
REQ-029 Reset asserted mid-request SHALL abandon the request; an ack arriving during or after reset in IDLE is ignored.

Verification
REQ-030 Reset release, memory with zero-wait acks of 0x11111111, 0x22222222 -> imem_addr 0,4,8...; the outputs (0,0x11111111,valid) then (4,0x22222222,valid) on consecutive cycles.
REQ-031 Ack at addr 8 while stall=1 for 3 cycles -> outputs hold previous values, imem_req=0 in HOLD; after stall drops, pc_out=8 with valid_out=1, next imem_addr=0xC.
REQ-032 branch_taken with target 0x1002 while the request at 0x10 is pending, ack 2 cycles later -> ack data dropped, valid_out=0, next imem_addr=0x1000.
REQ-033 branch_taken and ack in the same cycle, with stall=1 -> data dropped, valid_out=0, imem_addr=target the next cycle.
REQ-034 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> the second fetch address is 0.
REQ-035 rst_n low mid-DISCARD with ack arriving during reset -> all outputs at their reset values; after release, first imem_addr=RESET_PC.

Source files
------------

// File: rtl/etapa_if.sv
// etapa_if -- instruction fetch stage.
//
// Issues one instruction-memory request at a time, delivers fetched words to
// the IF/ID buffer, honours a downstream stall and redirects on a taken branch.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   stall            downstream hold: outputs must not change while high
//   branch_taken     redirect request from execute
//   branch_target    redirect address (bits [1:0] ignored)
//   imem_req         registered request to instruction memory
//   imem_addr        fetch address, stable until the request is acked
//   imem_ack         one-cycle acceptance pulse, imem_rdata valid that cycle
//   imem_rdata       fetched instruction word
//   instr_out        instruction to IF/ID (NOP_INSTR while nothing is held)
//   pc_out           address of instr_out
//   valid_out        1 = instr_out/pc_out is a real instruction
module etapa_if #(
   parameter logic [63:0] RESET_PC  = 64'h0,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [63:0] branch_target,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [63:0] pc_out,
   output logic        valid_out
);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD, HOLD} state_t;

   state_t      state;
   logic [63:0] pc;
   logic [63:0] hold_pc;
   logic [31:0] hold_instr;

   logic [63:0] target_aligned;
   logic [63:0] pc_next;

   assign target_aligned = {branch_target[63:2], 2'b00};
   assign pc_next        = pc + 64'd4;   // wraps modulo 2^64

   // In DISCARD, pc already holds the redirect target while imem_addr keeps
   // the outstanding address until its ack; hence the separate address reg.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         imem_req   <= 1'b0;
         imem_addr  <= RESET_PC;
         instr_out  <= NOP_INSTR;
         pc_out     <= '0;
         valid_out  <= 1'b0;
         hold_pc    <= '0;
         hold_instr <= '0;
      end else begin
         case (state)
            IDLE: begin
               state     <= REQ;
               imem_req  <= 1'b1;
               imem_addr <= pc;
            end

            REQ: begin
               if (branch_taken) begin
                  pc         <= target_aligned;
                  valid_out  <= 1'b0;
                  hold_pc    <= '0;
                  hold_instr <= '0;
                  if (imem_ack) begin
                     imem_addr <= target_aligned;
                  end else begin
                     state <= DISCARD;
                  end
               end else if (imem_ack) begin
                  if (stall) begin
                     hold_instr <= imem_rdata;
                     hold_pc    <= pc;
                     imem_req   <= 1'b0;
                     state      <= HOLD;
                  end else begin
                     instr_out <= imem_rdata;
                     pc_out    <= pc;
                     valid_out <= 1'b1;
                     pc        <= pc_next;
                     imem_addr <= pc_next;
                  end
               end else if (!stall) begin
                  valid_out <= 1'b0;
               end
            end

            DISCARD: begin
               if (branch_taken) begin
                  pc         <= target_aligned;
                  valid_out  <= 1'b0;
                  hold_pc    <= '0;
                  hold_instr <= '0;
                  if (imem_ack) begin
                     imem_addr <= target_aligned;
                     state     <= REQ;
                  end
               end else if (imem_ack) begin
                  imem_addr <= pc;
                  state     <= REQ;
               end
            end

            HOLD: begin
               if (branch_taken) begin
                  pc         <= target_aligned;
                  valid_out  <= 1'b0;
                  hold_pc    <= '0;
                  hold_instr <= '0;
                  imem_req   <= 1'b1;
                  imem_addr  <= target_aligned;
                  state      <= REQ;
               end else if (!stall) begin
                  instr_out <= hold_instr;
                  pc_out    <= hold_pc;
                  valid_out <= 1'b1;
                  pc        <= pc_next;
                  imem_req  <= 1'b1;
                  imem_addr <= pc_next;
                  state     <= REQ;
               end
            end

            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_etapa_if.sv
// tb_etapa_if -- directed scenarios followed by randomized traffic, checked
// against a transaction-level fetch model (program-order pc, one pending
// request with a "stale" flag, one buffered word).
module tb_etapa_if;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   logic        imem_req;
   logic [63:0] imem_addr;
   logic [31:0] instr_out;
   logic [63:0] pc_out;
   logic        valid_out;

   logic        w_req;
   logic [63:0] w_addr;
   logic [31:0] w_instr;
   logic [63:0] w_pc;
   logic        w_valid;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [31:0] NOP = 32'h00000013;

   always #5 clk = ~clk;

   etapa_if u_dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_out(instr_out),
      .pc_out(pc_out), .valid_out(valid_out)
   );

   etapa_if #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_out(w_instr),
      .pc_out(w_pc), .valid_out(w_valid)
   );

   // ---------------- reference model ----------------
   logic        m_started, m_pending, m_stale, m_buf_valid, m_valid;
   logic [63:0] m_addr, m_next_pc, m_buf_pc, m_pc;
   logic [31:0] m_buf_instr, m_instr;

   function automatic logic [31:0] mem(input logic [63:0] a);
      if (a == 64'h0) return 32'h11111111;
      if (a == 64'h4) return 32'h22222222;
      return (a[31:0] ^ a[63:32]) * 32'h9E3779B1 + 32'h5;
   endfunction

   task automatic model_reset();
      m_started = 0; m_pending = 0; m_stale = 0; m_buf_valid = 0;
      m_addr = 64'h0; m_next_pc = 64'h0; m_buf_pc = '0; m_buf_instr = '0;
      m_instr = NOP; m_pc = 64'h0; m_valid = 0;
   endtask

   task automatic deliver(input logic [31:0] ins, input logic [63:0] a);
      m_instr = ins; m_pc = a; m_valid = 1; m_next_pc = a + 64'd4;
   endtask

   task automatic model_clock();
      if (!m_started) begin
         m_started = 1; m_pending = 1; m_addr = m_next_pc;
      end else if (branch_taken) begin
         m_next_pc = {branch_target[63:2], 2'b00};
         m_valid = 0; m_buf_valid = 0;
         if (m_pending && !imem_ack) m_stale = 1;
         else begin m_pending = 1; m_stale = 0; m_addr = m_next_pc; end
      end else if (m_buf_valid) begin
         if (!stall) begin
            deliver(m_buf_instr, m_buf_pc);
            m_buf_valid = 0; m_pending = 1; m_addr = m_next_pc;
         end
      end else if (m_pending && imem_ack) begin
         if (m_stale) begin
            m_stale = 0; m_addr = m_next_pc;
         end else if (stall) begin
            m_buf_instr = imem_rdata; m_buf_pc = m_addr; m_buf_valid = 1; m_pending = 0;
         end else begin
            deliver(imem_rdata, m_addr);
            m_addr = m_next_pc;
         end
      end else if (m_pending && !m_stale && !stall) begin
         m_valid = 0;
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      chk({tag, ".req"},   {63'd0, imem_req},  {63'd0, m_pending});
      chk({tag, ".addr"},  imem_addr,          m_addr);
      chk({tag, ".instr"}, {32'd0, instr_out}, {32'd0, m_instr});
      chk({tag, ".pc"},    pc_out,             m_pc);
      chk({tag, ".valid"}, {63'd0, valid_out}, {63'd0, m_valid});
   endtask

   task automatic step(input string tag, input logic rv, input logic br,
                       input logic [63:0] tgt, input logic st, input logic ak);
      @(negedge clk);
      rst_n = rv; branch_taken = br; branch_target = tgt; stall = st; imem_ack = ak;
      imem_rdata = ak ? mem(imem_addr) : $urandom;
      if (!rv) begin
         model_reset();
         #1 compare_all({tag, ".async"});
      end else begin
         model_clock();
      end
      @(posedge clk); #1;
      compare_all(tag);
   endtask

   initial begin
      rst_n = 0; stall = 0; branch_taken = 0; branch_target = '0;
      imem_ack = 0; imem_rdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("por");
      chk("por.wrap_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);

      // zero-wait fetch stream
      step("r030a", 1, 0, 0, 0, 0);
      chk("r030a.wrap_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      step("r030b", 1, 0, 0, 0, 1);
      chk("r030b.pc", pc_out, 64'h0);
      chk("r030b.instr", {32'd0, instr_out}, 64'h11111111);
      chk("r030b.wrap_addr", w_addr, 64'h0);
      step("r030c", 1, 0, 0, 0, 1);
      chk("r030c.pc", pc_out, 64'h4);
      chk("r030c.instr", {32'd0, instr_out}, 64'h22222222);

      // ack at 8 under a 3-cycle stall
      step("r031a", 1, 0, 0, 1, 1);
      chk("r031a.req", {63'd0, imem_req}, 64'd0);
      step("r031b", 1, 0, 0, 1, 0);
      step("r031c", 1, 0, 0, 1, 0);
      chk("r031c.pc_held", pc_out, 64'h4);
      step("r031d", 1, 0, 0, 0, 0);
      chk("r031d.pc", pc_out, 64'h8);
      chk("r031d.valid", {63'd0, valid_out}, 64'd1);
      chk("r031d.addr", imem_addr, 64'hC);

      // redirect while request at 0x10 is pending
      step("r032a", 1, 0, 0, 0, 1);
      step("r032b", 1, 1, 64'h1002, 0, 0);
      chk("r032b.addr_outstanding", imem_addr, 64'h10);
      step("r032c", 1, 0, 0, 0, 0);
      step("r032d", 1, 0, 0, 0, 1);
      chk("r032d.addr", imem_addr, 64'h1000);
      chk("r032d.valid", {63'd0, valid_out}, 64'd0);

      // redirect + ack + stall in one cycle
      step("r033", 1, 1, 64'h2000, 1, 1);
      chk("r033.addr", imem_addr, 64'h2000);
      chk("r033.valid", {63'd0, valid_out}, 64'd0);

      // reset in DISCARD with ack during reset
      step("r035a", 1, 1, 64'h3000, 0, 0);
      step("r035b", 0, 0, 0, 0, 1);
      step("r035c", 0, 0, 0, 0, 1);
      chk("r035c.instr", {32'd0, instr_out}, {32'd0, NOP});
      step("r035d", 1, 0, 0, 0, 1);
      chk("r035d.addr", imem_addr, 64'h0);
      chk("r035d.req", {63'd0, imem_req}, 64'd1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic        br, st, ak;
         logic [63:0] tgt;
         if ($urandom_range(399) == 0) begin
            step("rnd_rst", 0, 0, 0, 0, 1'($urandom_range(1)));
            step("rnd_rst", 0, 0, 0, 0, 1'($urandom_range(1)));
         end
         br  = ($urandom_range(9) == 0);
         tgt = ($urandom_range(3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15))
                                        : {32'($urandom), 32'($urandom)};
         st  = ($urandom_range(2) == 0);
         ak  = m_pending ? 1'($urandom_range(1)) : ($urandom_range(7) == 0);
         step("rnd", 1, br, tgt, st, ak);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
